uart_rx_fifo_ctrl: RTL
======================

UART_RX_FIFO_CTRL -- requirements
Module: uart_rx_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter PAYLOAD_BITS, default 8, giving the received character width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, giving the number of buffered characters; it SHALL be a power of two, at least 2.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 4000, giving the idle clk cycles before the receive-timeout flag sets.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all logic SHALL be on the rising edge.
REQ-005 The block SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port rx_enable, input, 1 bit: when 1, characters from the receiver are accepted.
REQ-007 The block SHALL have port rx_ready, input, 1 bit: single-cycle pulse from the receiver that a character is valid.
REQ-008 The block SHALL have port rx_data, input, PAYLOAD_BITS bits: received character, valid while rx_ready=1.
REQ-009 The block SHALL have port rd_en, input, 1 bit: pop request from the bus side.
REQ-010 The block SHALL have port flush, input, 1 bit: discard all buffered characters.
REQ-011 The block SHALL have port ovr_clr, input, 1 bit: clear the sticky overrun flag.
REQ-012 The block SHALL have port irq_level, input, $clog2(FIFO_DEPTH)+1 bits: level interrupt threshold; 0 disables the level interrupt.
REQ-013 The block SHALL have port rd_data, output, PAYLOAD_BITS bits: popped character.
REQ-014 The block SHALL have port rd_valid, output, 1 bit: 1-cycle strobe that rd_data holds a popped character.
REQ-015 The block SHALL have port level, output, $clog2(FIFO_DEPTH)+1 bits: current occupancy.
REQ-016 The block SHALL have ports empty and full, output, 1 bit each: occupancy flags.
REQ-017 The block SHALL have port overrun, output, 1 bit: sticky flag, set when a character was lost.
REQ-018 The block SHALL have port timeout, output, 1 bit: receive-timeout flag.
REQ-019 The block SHALL have port irq, output, 1 bit: registered interrupt request.

Function
REQ-020 The control FSM SHALL have states DISABLED and RUN; it SHALL go DISABLED->RUN when rx_enable=1 and RUN->DISABLED when rx_enable=0, each one cycle later.
REQ-021 Write: in RUN with rx_ready=1 and space available, the block SHALL store rx_data at the write pointer and increment level.
REQ-022 In DISABLED, the block SHALL ignore rx_ready, store nothing and leave overrun unchanged.
REQ-023 Read: with rd_en=1 and level>0, the block SHALL drive the oldest character on rd_data with rd_valid=1 the next cycle (latency 1) and decrement level.
REQ-024 rd_en with level=0 SHALL be ignored: no rd_valid, rd_data held, no error flag.
REQ-025 Pointers SHALL be $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; level SHALL never exceed FIFO_DEPTH or go below 0.
REQ-026 Simultaneous accepted write and read SHALL leave level unchanged, including when full: the read frees the slot and the write is accepted, with no overrun.
REQ-027 Write at full without a read SHALL drop rx_data, keep buffer contents and set overrun the next cycle.
REQ-028 ovr_clr SHALL clear overrun, but a new overrun in the same cycle SHALL take priority and overrun SHALL stay 1.
REQ-029 Flush SHALL zero the pointers and level and clear timeout the next cycle, leave overrun unchanged, and take priority over a same-cycle write or read (no rd_valid).
REQ-030 Timeout counter: it SHALL run while level>0 and the FSM is in RUN, and reset to 0 on any accepted write, read, flush, or when level=0.
REQ-031 timeout SHALL set when the counter reaches TIMEOUT_CYCLES and stay set until the next accepted read, write or flush.
REQ-032 irq SHALL be registered as (irq_level!=0 && level>=irq_level) || timeout || overrun, evaluated on current-cycle flags, so irq follows the flags by one cycle.
REQ-033 empty SHALL equal (level==0) and full SHALL equal (level==FIFO_DEPTH), both combinational from level.

Reset
REQ-034 With resetn=0 at a clock edge, the block SHALL set FSM=DISABLED, pointers=0, level=0, empty=1, full=0, rd_data=0, rd_valid=0, overrun=0, timeout=0, timeout counter=0, irq=0.
REQ-035 Reset mid-operation SHALL discard buffered characters; buffer RAM contents need not be cleared.

Verification
REQ-036 Bench: enable, push 0x41,0x42,0x43, then three rd_en -> rd_valid one cycle after each rd_en with 0x41,0x42,0x43 in order; level 3->0; empty=1.
REQ-037 Bench: push 17 characters with no reads at depth 16 -> full=1, level=16, overrun=1, irq=1; 16 reads return the first 16 characters; ovr_clr -> overrun=0.
REQ-038 Bench: at full, rx_ready and rd_en in the same cycle -> level stays 16, overrun=0, new character read out last.
REQ-039 Bench: irq_level=4, push 3 -> irq=0; 4th push -> irq=1 one cycle later; one read -> irq=0.
REQ-040 Bench: TIMEOUT_CYCLES=10, push 1 character, idle -> timeout=1 after 10 cycles; read -> timeout=0; rx_ready during DISABLED -> level unchanged.
REQ-041 Bench: level=5, then flush with a simultaneous rx_ready -> level=0 next cycle; then resetn=0 mid-stream -> all outputs at reset values.

Source files
------------

// File: rtl/uart_rx_fifo_ctrl.sv
// UART receive buffer: character FIFO with overrun and idle-timeout tracking
// and a registered interrupt, gated by a DISABLED/RUN enable FSM.
module uart_rx_fifo_ctrl #(
    parameter int unsigned PAYLOAD_BITS   = 8,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4000
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          rx_enable,
    input  logic                          rx_ready,
    input  logic [PAYLOAD_BITS-1:0]       rx_data,
    input  logic                          rd_en,
    input  logic                          flush,
    input  logic                          ovr_clr,
    input  logic [$clog2(FIFO_DEPTH):0]   irq_level,
    output logic [PAYLOAD_BITS-1:0]       rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          empty,
    output logic                          full,
    output logic                          overrun,
    output logic                          timeout,
    output logic                          irq
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {
        ST_DISABLED = 1'b0,
        ST_RUN      = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic                    run_c;

    logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]           level_q, level_d;
    logic [PAYLOAD_BITS-1:0] rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    overrun_q, overrun_d;
    logic                    timeout_q, timeout_d;
    logic [TW-1:0]           tmo_cnt_q, tmo_cnt_d;
    logic                    irq_q, irq_d;

    logic                    empty_c, full_c;
    logic                    rd_acc_c, wr_acc_c, ovr_set_c, activity_c;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= ST_DISABLED;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DISABLED: if (rx_enable)  state_d = ST_RUN;
            ST_RUN:      if (!rx_enable) state_d = ST_DISABLED;
            default:     state_d = ST_DISABLED;
        endcase
    end

    // FSM outputs
    always_comb begin
        run_c = 1'b0;
        if (state_q == ST_RUN) run_c = 1'b1;
    end

    assign empty_c = (level_q == '0);
    assign full_c  = (level_q == LW'(FIFO_DEPTH));

    // Flush wins over everything; a read at full frees the slot for a same-cycle write.
    assign rd_acc_c   = rd_en && !empty_c && !flush;
    assign wr_acc_c   = run_c && rx_ready && !flush && (!full_c || rd_acc_c);
    assign ovr_set_c  = run_c && rx_ready && !flush && !wr_acc_c;
    assign activity_c = flush || wr_acc_c || rd_acc_c;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_acc_c;
        overrun_d  = overrun_q;
        timeout_d  = timeout_q;
        tmo_cnt_d  = tmo_cnt_q;
        irq_d      = ((irq_level != '0) && (level_q >= irq_level)) || timeout_q || overrun_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_acc_c) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_acc_c) begin
                rd_ptr_d  = rd_ptr_q + PW'(1);
                rd_data_d = mem_q[rd_ptr_q];
            end
            level_d = level_q + LW'(wr_acc_c) - LW'(rd_acc_c);
        end

        if (ovr_set_c)    overrun_d = 1'b1;
        else if (ovr_clr) overrun_d = 1'b0;

        // Idle counter saturates at the threshold and freezes while disabled.
        if (activity_c || empty_c)
            tmo_cnt_d = '0;
        else if (run_c && (tmo_cnt_q != TW'(TIMEOUT_CYCLES)))
            tmo_cnt_d = tmo_cnt_q + TW'(1);

        if (activity_c)                            timeout_d = 1'b0;
        else if (tmo_cnt_d == TW'(TIMEOUT_CYCLES)) timeout_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            tmo_cnt_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
            tmo_cnt_q  <= tmo_cnt_d;
            irq_q      <= irq_d;
        end
    end

    // Buffer RAM is not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (resetn && wr_acc_c) mem_q[wr_ptr_q] <= rx_data;
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign level    = level_q;
    assign empty    = empty_c;
    assign full     = full_c;
    assign overrun  = overrun_q;
    assign timeout  = timeout_q;
    assign irq      = irq_q;

endmodule
